nibble_fifo: RTL and testbench

NIBBLE_FIFO -- requirements
Module: nibble_fifo

---
 rtl/nibble_fifo_pkg.sv | 17 +
 rtl/nibble_fifo_ptr.sv | 28 ++
 rtl/nibble_fifo.sv | 81 ++++++++
 tb/tb_nibble_fifo.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/nibble_fifo_pkg.sv
// Shared FIFO sizing defaults and the request-combination encoding,
// imported by the FIFO, its pointer counters and the bench.
package nibble_fifo_pkg;

  localparam int FIFO_WIDTH = 4;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH);

  // Accepted-operation mix on one edge, {write, read}
  typedef enum logic [1:0] {
    OP_NONE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/nibble_fifo_ptr.sv
// Modulo-DEPTH up-counter used for the FIFO read and write pointers.
module fifo_ptr
  import nibble_fifo_pkg::*;
#(
  parameter int AW = FIFO_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          inc,
  output logic [AW-1:0] ptr
);

  logic [AW-1:0] ptr_q, ptr_d;

  // DEPTH is a power of two, so natural AW-bit rollover is the modulo wrap
  always_comb begin
    ptr_d = ptr_q;
    if (inc) ptr_d = ptr_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/nibble_fifo.sv
// Synchronous FIFO with registered read data, occupancy count and
// one-cycle overflow/underflow pulses for rejected requests.
module nibble_fifo
  import nibble_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH,
  parameter int AW    = FIFO_AW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] q,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic             ovf,
  output logic             udf
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] q_q, q_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d, udf_q, udf_d;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_acc, rd_acc;
  fifo_op_e         op;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A read frees a slot on the same edge, so a full FIFO still takes a write
  assign rd_acc = rd_en && !empty;
  assign wr_acc = wr_en && (!full || rd_acc);
  assign op     = fifo_op_e'({wr_acc, rd_acc});

  always_comb begin
    count_d = count_q;
    q_d     = q_q;
    ovf_d   = wr_en && !wr_acc;
    udf_d   = rd_en && !rd_acc;
    case (op)
      OP_WR:   count_d = count_q + 1'b1;
      OP_RD:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (rd_acc) q_d = mem_q[rd_ptr];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q     <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      q_q     <= q_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage is never read before written, so it carries no reset
  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr] <= d;
  end

  fifo_ptr #(.AW(AW)) u_wr_ptr (.clk(clk), .rst(rst), .inc(wr_acc), .ptr(wr_ptr));
  fifo_ptr #(.AW(AW)) u_rd_ptr (.clk(clk), .rst(rst), .inc(rd_acc), .ptr(rd_ptr));

  assign q     = q_q;
  assign count = count_q;
  assign ovf   = ovf_q;
  assign udf   = udf_q;

endmodule

// File: tb/tb_nibble_fifo.sv
// Randomized and directed bench for nibble_fifo against a queue-based model.
module tb_nibble_fifo;
  import nibble_fifo_pkg::*;

  localparam int W  = FIFO_WIDTH;
  localparam int DP = FIFO_DEPTH;
  localparam int A  = FIFO_AW;

  logic         clk = 1'b1;
  logic         rst;
  logic [W-1:0] d;
  logic         wr_en, rd_en;
  logic [W-1:0] q;
  logic         full, empty, ovf, udf;
  logic [A:0]   count;

  int n_chk  = 0;
  int n_fail = 0;

  logic [W-1:0] mq[$];
  logic [W-1:0] q_exp;
  logic         ovf_exp, udf_exp;

  nibble_fifo dut (
    .clk(clk), .rst(rst), .d(d), .wr_en(wr_en), .rd_en(rd_en),
    .q(q), .full(full), .empty(empty), .count(count), .ovf(ovf), .udf(udf)
  );

  // Rising edges at 10, 20, 30 ... ns
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string ph);
    chk({ph, ".q"},     32'(q),     32'(q_exp));
    chk({ph, ".count"}, 32'(count), 32'(mq.size()));
    chk({ph, ".full"},  32'(full),  32'(mq.size() == DP));
    chk({ph, ".empty"}, 32'(empty), 32'(mq.size() == 0));
    chk({ph, ".ovf"},   32'(ovf),   32'(ovf_exp));
    chk({ph, ".udf"},   32'(udf),   32'(udf_exp));
  endtask

  // One clock: apply requests, advance the model, compare 1 ns after the edge
  task automatic step(input string ph, input logic wr, input logic rd, input logic [W-1:0] din);
    bit racc, wacc;
    wr_en = wr; rd_en = rd; d = din;
    racc = rd && (mq.size() > 0);
    wacc = wr && ((mq.size() < DP) || racc);
    @(posedge clk); #1;
    if (racc) q_exp = mq.pop_front();
    if (wacc) mq.push_back(din);
    ovf_exp = wr && !wacc;
    udf_exp = rd && !racc;
    wr_en = 1'b0; rd_en = 1'b0;
    chk_all(ph);
  endtask

  function automatic void model_reset();
    mq.delete();
    q_exp = '0; ovf_exp = 1'b0; udf_exp = 1'b0;
  endfunction

  initial begin
    rst = 1'b1; d = '0; wr_en = 1'b0; rd_en = 1'b0;
    model_reset();
    #5 rst = 1'b0;
    #1;
    chk_all("reset");
    chk("reset.q_const", 32'(q), 32'h0);

    // Fill to full, then one rejected write
    step("fill", 1, 0, 4'b1010);
    step("fill", 1, 0, 4'b0101);
    step("fill", 1, 0, 4'b1111);
    step("fill", 1, 0, 4'b0011);
    chk("fill.full_const", 32'(full), 32'h1);
    step("ovf", 1, 0, 4'b1000);
    chk("ovf.count_const", 32'(count), 32'd4);
    step("ovf_clear", 0, 0, 4'b0000);

    // Drain in order, then one rejected read
    step("drain", 0, 1, 4'b0000);
    chk("drain.q0", 32'(q), 32'b1010);
    step("drain", 0, 1, 4'b0000);
    step("drain", 0, 1, 4'b0000);
    step("drain", 0, 1, 4'b0000);
    chk("drain.q3", 32'(q), 32'b0011);
    step("udf", 0, 1, 4'b0000);
    chk("udf.q_hold", 32'(q), 32'b0011);

    // Wrap-around with interleaved reads
    step("wrap", 1, 0, 4'd1);
    step("wrap", 1, 0, 4'd2);
    for (int i = 3; i <= 6; i++) step("wrap", 1, 1, 4'(i));
    step("wrap", 0, 1, 4'd0);
    step("wrap", 0, 1, 4'd0);
    chk("wrap.last", 32'(q), 32'd6);

    // Simultaneous read+write when full
    for (int i = 0; i < 4; i++) step("simf_fill", 1, 0, 4'(8 + i));
    step("sim_full", 1, 1, 4'hc);
    chk("sim_full.q_oldest", 32'(q), 32'h8);
    chk("sim_full.count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) step("simf_drain", 0, 1, 4'h0);

    // Simultaneous read+write when empty
    step("sim_empty", 1, 1, 4'h7);
    chk("sim_empty.count", 32'(count), 32'd1);
    step("sim_empty_rd", 0, 1, 4'h0);

    // Asynchronous reset between edges with three words stored
    for (int i = 0; i < 3; i++) step("mid_fill", 1, 0, 4'(i + 4'h9));
    step("mid_rd", 0, 1, 4'h0);
    step("mid_fill", 1, 0, 4'he);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.count", 32'(count), 32'd0);
    chk("midrst.q", 32'(q), 32'h0);
    chk("midrst.empty", 32'(empty), 32'd1);
    #1 rst = 1'b0;
    step("post_rst_wr", 1, 0, 4'h5);
    step("post_rst_rd", 0, 1, 4'h0);
    chk("post_rst.q", 32'(q), 32'h5);

    // Random traffic in phases with different read/write bias
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 150; i++) begin
        logic w, r;
        w = ($urandom_range(0, 9) < (ph == 0 ? 8 : ph == 1 ? 2 : 5));
        r = ($urandom_range(0, 9) < (ph == 0 ? 2 : ph == 1 ? 8 : 5));
        step("rand", w, r, 4'($urandom));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
